store_addr_queue: RTL
=====================

# store_addr_queue

Program-ordered store address queue for the AGU. Allocates one entry per store at dispatch (circular head/tail), receives resolved store addresses and byte masks out of order, and retires stores in order from the head. Every cycle it checks one load address against all older stores and reports whether the load must wait or has a forwarding candidate. It replaces the flat tag-indexed address table with age-aware, mask-aware disambiguation, flush, and full/empty flow control.

## Interface
- WIDTH, 3: log2 of entry count; SIZE = 2**WIDTH.
- AWIDTH, 32: address width; word compare uses bits [AWIDTH-1:2].

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous clear of all entries.
- i_alloc  in  1  allocate one entry at the tail.
- o_alloc_ready  out  1  queue not full.
- o_alloc_idx  out  WIDTH  index the allocating store receives (tail[WIDTH-1:0]).
- o_alloc_tail  out  WIDTH+1  full tail pointer with wrap bit; loads capture it as their age.
- i_res_en  in  1  address resolve strobe.
- i_res_idx  in  WIDTH  entry being resolved.
- i_res_addr  in  AWIDTH  store address.
- i_res_mask  in  4  store byte mask.
- i_retire  in  1  dequeue head.
- o_retire_ready  out  1  head is allocated and resolved.
- o_retire_addr  out  AWIDTH  head address.
- o_retire_mask  out  4  head mask.
- i_ld_valid  in  1  load check request.
- i_ld_addr  in  AWIDTH  load address.
- i_ld_mask  in  4  load byte mask.
- i_ld_tail  in  WIDTH+1  tail pointer captured when the load was dispatched.
- o_ld_wait  out  1  some older store has an unresolved address.
- o_ld_match  out  1  some older resolved store overlaps the load.
- o_ld_fwd_idx  out  WIDTH  youngest older overlapping store.
- o_count  out  WIDTH+1  occupied entries.
- o_empty  out  1  count == 0.

## Operation
- Per-entry state: valid, resolved, addr, mask. Pointers head and tail are WIDTH+1 bits; count = tail - head.
- Reset: all entries invalid/unresolved, addr/mask 0, head = tail = 0. Output reset values: o_alloc_ready=1, o_alloc_idx=0, o_alloc_tail=0, o_retire_ready=0, o_retire_addr=0, o_retire_mask=0, o_ld_wait=0, o_ld_match=0, o_ld_fwd_idx=0, o_count=0, o_empty=1.
- Priority per cycle: flush > {alloc, resolve, retire}. A flush clears all valid/resolved bits, sets head = tail = 0, and drops same-cycle alloc, resolve and retire.
- Alloc: taken when i_alloc && o_alloc_ready. Sets valid, clears resolved at the tail, then tail+1. When full, i_alloc is ignored with no state change.
- Resolve: writes addr/mask and sets resolved at i_res_idx only if that entry is valid. A resolve of an invalid entry is dropped. A re-resolve overwrites.
- Retire: taken when i_retire && o_retire_ready. Clears valid/resolved at the head, then head+1. i_retire while not ready is ignored.
- Alloc and retire in the same cycle are both taken: count is unchanged and pointers advance independently.
- Load check, combinational from registered state:
  - Entry i is older when valid and ((i - head[WIDTH-1:0]) mod SIZE) < (i_ld_tail - head) mod 2**(WIDTH+1).
  - o_ld_wait = i_ld_valid && any older entry is unresolved.
  - Overlap = resolved && addr[AWIDTH-1:2] == i_ld_addr[AWIDTH-1:2] && (mask & i_ld_mask) != 0.
  - o_ld_match = i_ld_valid && any older entry overlaps.
  - o_ld_fwd_idx = the overlapping older entry with the largest distance from head; 0 when there is no match.
  - When i_ld_valid=0, all three load outputs are 0.

## Timing
- o_alloc_idx and o_alloc_tail are combinational from tail, valid in the request cycle. The new entry is visible to the load check from the next cycle.
- A resolve is visible to the load check and to o_retire_ready one cycle after the strobe edge; there is no same-cycle bypass.
- o_alloc_ready, o_count and o_empty are registered-state derived and reflect the previous edge. A same-cycle retire does not free space for a same-cycle alloc when full.
- Asynchronous reset mid-operation discards all entries immediately. The first allocation after reset gets idx 0.

## Test plan
- Reset, then alloc 8 stores (WIDTH=3) -> idx 0..7, o_count=8, o_alloc_ready=0. Ninth alloc is ignored and tail is unchanged.
- Resolve idx 2 addr 0x100 mask 0xF. Load at 0x102, mask 0x4, i_ld_tail=8, with idx 0,1,3.. unresolved -> o_ld_wait=1, o_ld_match=1, o_ld_fwd_idx=2.
- Resolve idx 1 and idx 4 both at 0x200 mask 0x3. Load at 0x200, mask 0x1, i_ld_tail=4 -> o_ld_fwd_idx=1, because idx 4 is younger than the load. With mask 0xC instead -> o_ld_match=0.
- Wrap test: head=6, tail=10 (entries 6,7,0,1), with all four resolved. i_ld_tail=9 -> only 6,7,0 are older; a match on idx 1 is not reported.
- Full queue with i_alloc and i_retire in the same cycle, head resolved -> retire is taken, alloc is refused, o_count=7. Next cycle, i_alloc and i_retire together are both taken and o_count stays 7.
- i_flush together with i_alloc and i_res_en -> next cycle o_count=0, o_empty=1, o_alloc_idx=0, all load outputs 0.

Source files
------------

// File: rtl/store_addr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : store_addr_queue
//  Description : Program-ordered store address queue. Stores take an entry at
//                dispatch (circular tail), resolve their address and byte mask
//                out of order, and retire in order from the head. Each cycle
//                one load is checked against all stores older than it for
//                unresolved hazards and for a forwarding candidate.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_addr_queue #(
    parameter int WIDTH  = 3,
    parameter int AWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_alloc,
    output logic              o_alloc_ready,
    output logic [WIDTH-1:0]  o_alloc_idx,
    output logic [WIDTH:0]    o_alloc_tail,
    input  logic              i_res_en,
    input  logic [WIDTH-1:0]  i_res_idx,
    input  logic [AWIDTH-1:0] i_res_addr,
    input  logic [3:0]        i_res_mask,
    input  logic              i_retire,
    output logic              o_retire_ready,
    output logic [AWIDTH-1:0] o_retire_addr,
    output logic [3:0]        o_retire_mask,
    input  logic              i_ld_valid,
    input  logic [AWIDTH-1:0] i_ld_addr,
    input  logic [3:0]        i_ld_mask,
    input  logic [WIDTH:0]    i_ld_tail,
    output logic              o_ld_wait,
    output logic              o_ld_match,
    output logic [WIDTH-1:0]  o_ld_fwd_idx,
    output logic [WIDTH:0]    o_count,
    output logic              o_empty
);

    localparam int           SIZE  = 2 ** WIDTH;
    localparam logic [WIDTH:0] c_one  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] c_full = (WIDTH+1)'(SIZE);

    // Per-entry state and circular pointers (pointers carry a wrap bit).
    logic [SIZE-1:0]   r_valid;
    logic [SIZE-1:0]   r_resolved;
    logic [AWIDTH-1:0] r_addr [SIZE];
    logic [3:0]        r_mask [SIZE];
    logic [WIDTH:0]    r_head;
    logic [WIDTH:0]    r_tail;

    logic [WIDTH:0]    w_count;
    logic              w_full;
    logic [WIDTH-1:0]  w_head_idx;
    logic [WIDTH-1:0]  w_tail_idx;
    logic              w_alloc_take;
    logic              w_retire_take;
    logic              w_res_take;

    logic [WIDTH:0]    w_ld_span;
    logic [WIDTH-1:0]  w_dist    [SIZE];
    logic [SIZE-1:0]   w_older;
    logic [SIZE-1:0]   w_pending;
    logic [SIZE-1:0]   w_overlap;
    logic [WIDTH-1:0]  w_fwd_idx;
    logic [WIDTH-1:0]  w_scan;

    // Only the word part of the load address takes part in disambiguation.
    logic              w_unused_ld_lo;
    assign w_unused_ld_lo = ^i_ld_addr[1:0];

    assign w_count     = r_tail - r_head;
    assign w_full      = (w_count == c_full);
    assign w_head_idx  = r_head[WIDTH-1:0];
    assign w_tail_idx  = r_tail[WIDTH-1:0];

    // A same-cycle retire never frees space for a same-cycle alloc.
    assign w_alloc_take  = i_alloc && !w_full;
    assign w_retire_take = i_retire && o_retire_ready;
    assign w_res_take    = i_res_en && r_valid[i_res_idx];

    assign o_alloc_ready  = !w_full;
    assign o_alloc_idx    = w_tail_idx;
    assign o_alloc_tail   = r_tail;
    assign o_count        = w_count;
    assign o_empty        = (w_count == '0);
    assign o_retire_ready = r_valid[w_head_idx] && r_resolved[w_head_idx];
    assign o_retire_addr  = r_addr[w_head_idx];
    assign o_retire_mask  = r_mask[w_head_idx];

    // Number of queue slots, counted from the head, that precede the load.
    assign w_ld_span = i_ld_tail - r_head;

    // Per-entry age classification and overlap against the current load.
    for (genvar g = 0; g < SIZE; g++) begin : g_entry
        assign w_dist[g]    = WIDTH'(g) - w_head_idx;
        assign w_older[g]   = r_valid[g] && ({1'b0, w_dist[g]} < w_ld_span);
        assign w_pending[g] = w_older[g] && !r_resolved[g];
        assign w_overlap[g] = w_older[g] && r_resolved[g]
                              && (r_addr[g][AWIDTH-1:2] == i_ld_addr[AWIDTH-1:2])
                              && ((r_mask[g] & i_ld_mask) != 4'b0000);
    end

    // Walk from head toward tail so the youngest overlapping store wins.
    always_comb begin
        w_fwd_idx = '0;
        w_scan    = '0;
        for (int d = 0; d < SIZE; d++) begin
            w_scan = w_head_idx + WIDTH'(d);
            if (w_overlap[w_scan]) begin
                w_fwd_idx = w_scan;
            end
        end
    end

    assign o_ld_wait    = i_ld_valid && (|w_pending);
    assign o_ld_match   = i_ld_valid && (|w_overlap);
    assign o_ld_fwd_idx = (i_ld_valid && (|w_overlap)) ? w_fwd_idx : '0;

    // Queue state update: flush dominates; retire clears after a same-index resolve.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_addr[i] <= '0;
                r_mask[i] <= '0;
            end
        end else if (i_flush) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (w_res_take) begin
                r_addr[i_res_idx]     <= i_res_addr;
                r_mask[i_res_idx]     <= i_res_mask;
                r_resolved[i_res_idx] <= 1'b1;
            end
            if (w_retire_take) begin
                r_valid[w_head_idx]    <= 1'b0;
                r_resolved[w_head_idx] <= 1'b0;
                r_head                 <= r_head + c_one;
            end
            if (w_alloc_take) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_resolved[w_tail_idx] <= 1'b0;
                r_tail                 <= r_tail + c_one;
            end
        end
    end

endmodule
`default_nettype wire
